// File: rtl/seq_core_mem_responder_pkg.sv
// Shared widths, NOP word and FSM encodings for the
// seq_core memory responder.
package seq_core_mem_responder_pkg;

  localparam int A_SIZE = 16;
  localparam int D_SIZE = 32;
  localparam int I_SIZE = 32;

  localparam logic [I_SIZE-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    MEM_ST_LOAD = 1'b0,
    MEM_ST_RUN  = 1'b1
  } mem_st_e;

endpackage

// File: rtl/seq_core_mem_responder_read_pipe.sv
// Fixed-latency valid/data delay line for read returns.
// Ports: clk, rst (async low), in_valid/in_data -> out_valid/out_data.
module mem_read_pipe #(
  parameter int LAT    = 1,
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [D_SIZE-1:0] in_data,
  output logic              out_valid,
  output logic [D_SIZE-1:0] out_data
);

  logic [LAT-1:0]             v;
  logic [LAT-1:0][D_SIZE-1:0] d;

  // data stages only move with a valid beat, so the
  // last stage holds the most recent read result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      d <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];

endmodule

// File: rtl/seq_core_mem_responder.sv
// Program store (streamed in after reset) and data RAM for seq_core.
// Ports: pc/instruction, read_mem/write_mem/address/data_out/data_in/
// rd_valid, prog_load_* stream, core_run, addr_err; clk, rst (async low).
module seq_core_mem_responder
  import seq_core_mem_responder_pkg::*;
#(
  parameter int PROG_DEPTH   = 1024,
  parameter int DATA_DEPTH   = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [A_SIZE-1:0] pc,
  output logic [I_SIZE-1:0] instruction,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [A_SIZE-1:0] address,
  input  logic [D_SIZE-1:0] data_out,
  output logic [D_SIZE-1:0] data_in,
  output logic              rd_valid,
  input  logic              prog_load_valid,
  input  logic [I_SIZE-1:0] prog_load_data,
  input  logic              prog_load_last,
  output logic              prog_load_ready,
  output logic              core_run,
  output logic              addr_err
);

  localparam int PW = $clog2(PROG_DEPTH);
  localparam int DW = $clog2(DATA_DEPTH);

  localparam logic [A_SIZE:0] PROG_LIM = (A_SIZE+1)'(PROG_DEPTH);
  localparam logic [A_SIZE:0] DATA_LIM = (A_SIZE+1)'(DATA_DEPTH);
  localparam logic [PW:0]     LAST_PTR = (PW+1)'(PROG_DEPTH - 1);

  mem_st_e state, state_nxt;

  logic [PW:0] load_ptr;

  logic [I_SIZE-1:0] prog [PROG_DEPTH];
  logic [D_SIZE-1:0] mem  [DATA_DEPTH];

  logic              run;
  logic              load_fire;
  logic              pc_ok;
  logic              addr_ok;
  logic [DW-1:0]     d_idx;
  logic              wr_fire;
  logic              rd_fire;
  logic [D_SIZE-1:0] rd_data;
  logic              err_nxt;

  assign run             = (state == MEM_ST_RUN);
  assign core_run        = run;
  assign prog_load_ready = !run;
  assign load_fire       = prog_load_valid & prog_load_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      MEM_ST_LOAD:
        if (load_fire &&
            (prog_load_last || load_ptr == LAST_PTR))
          state_nxt = MEM_ST_RUN;
      MEM_ST_RUN:
        state_nxt = MEM_ST_RUN;
      default:
        state_nxt = MEM_ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MEM_ST_LOAD;
      load_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (load_fire) load_ptr <= load_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) prog[load_ptr[PW-1:0]] <= prog_load_data;
  end

  assign pc_ok       = {1'b0, pc} < PROG_LIM;
  assign instruction = (run && pc_ok) ?
                       prog[pc[PW-1:0]] : NOP;

  assign addr_ok = {1'b0, address} < DATA_LIM;
  assign d_idx   = address[DW-1:0];

  // a colliding read is dropped; the write still lands
  assign wr_fire = run & write_mem & addr_ok;
  assign rd_fire = run & read_mem & ~write_mem;
  assign rd_data = addr_ok ? mem[d_idx] : '0;

  assign err_nxt = run &
                   (((read_mem | write_mem) & ~addr_ok) |
                    (read_mem & write_mem));

  always_ff @(posedge clk) begin
    if (wr_fire) mem[d_idx] <= data_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err <= 1'b0;
    else      addr_err <= err_nxt;
  end

  mem_read_pipe #(
    .LAT    (READ_LATENCY),
    .D_SIZE (D_SIZE)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .out_valid (rd_valid),
    .out_data  (data_in)
  );

endmodule
